// File: rtl/spi_flash_loader.sv
// Boot loader: drives an SPI controller's register port to stream a flash image
// (READ 0x03) into BRAM as little-endian 32-bit words, holding the CPU meanwhile.
module spi_flash_loader #(
  parameter logic [23:0] FLASH_ADDR = 24'h100000,
  parameter int          WORD_COUNT = 4096,
  parameter logic [31:0] CLK_DIV    = 32'd1
) (
  input  logic        CLK,
  input  logic        reset,
  output logic        spi_wen,
  output logic [31:0] spi_addr,
  output logic [31:0] spi_wdata,
  input  logic [31:0] spi_rdata,
  output logic [3:0]  mem_wen,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done
);

  localparam logic [31:0] REG_TX   = 32'd0;
  localparam logic [31:0] REG_DIV  = 32'd4;
  localparam logic [31:0] REG_RX   = 32'd8;
  localparam logic [31:0] REG_BUSY = 32'd12;
  localparam logic [31:0] REG_CS   = 32'd16;
  localparam logic [12:0] LAST_WORD = 13'(WORD_COUNT - 1);

  typedef enum logic [3:0] {
    IDLE_CS, SET_DIV, CS_LOW, SEND, POLL, RX_ADDR, RX_CAP, MEM_WR, CS_HIGH, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;   // 0..3 header bytes, 4..7 dummy byte lanes
  logic [1:0]  poll_cnt_q, poll_cnt_d;
  logic [12:0] word_cnt_q, word_cnt_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  tx_byte;

  logic        spi_wen_d, cpu_hold_d, done_d;
  logic [31:0] spi_addr_d, spi_wdata_d, mem_wdata_d;
  logic [3:0]  mem_wen_d;
  logic [11:0] mem_addr_d;

  logic unused_rdata;
  assign unused_rdata = ^spi_rdata[31:8];

  always_comb begin
    case (byte_cnt_q)
      3'd0:    tx_byte = 8'h03;
      3'd1:    tx_byte = FLASH_ADDR[23:16];
      3'd2:    tx_byte = FLASH_ADDR[15:8];
      3'd3:    tx_byte = FLASH_ADDR[7:0];
      default: tx_byte = 8'h00;
    endcase
  end

  // Each state computes the register-port values presented in the following cycle.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    poll_cnt_d  = poll_cnt_q;
    word_cnt_d  = word_cnt_q;
    word_d      = word_q;
    spi_wen_d   = 1'b0;
    spi_addr_d  = spi_addr;
    spi_wdata_d = spi_wdata;
    mem_wen_d   = 4'h0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    cpu_hold_d  = cpu_hold;
    done_d      = done;
    case (state_q)
      IDLE_CS: begin
        if (WORD_COUNT == 0) begin
          state_d    = DONE;
          cpu_hold_d = 1'b0;
          done_d     = 1'b1;
        end else begin
          spi_wen_d   = 1'b1;
          spi_addr_d  = REG_CS;
          spi_wdata_d = 32'd1;
          state_d     = SET_DIV;
        end
      end
      SET_DIV: begin
        spi_wen_d   = 1'b1;
        spi_addr_d  = REG_DIV;
        spi_wdata_d = CLK_DIV;
        state_d     = CS_LOW;
      end
      CS_LOW: begin
        spi_wen_d   = 1'b1;
        spi_addr_d  = REG_CS;
        spi_wdata_d = 32'd0;
        byte_cnt_d  = 3'd0;
        state_d     = SEND;
      end
      SEND: begin
        spi_wen_d   = 1'b1;
        spi_addr_d  = REG_TX;
        spi_wdata_d = {24'h0, tx_byte};
        poll_cnt_d  = 2'd0;
        state_d     = POLL;
      end
      POLL: begin
        // First two cycles here see read data for the write address; skip them.
        spi_addr_d = REG_BUSY;
        if (poll_cnt_q != 2'd2) begin
          poll_cnt_d = poll_cnt_q + 2'd1;
        end else if (!spi_rdata[0]) begin
          if (byte_cnt_q[2]) begin
            spi_addr_d = REG_RX;
            state_d    = RX_ADDR;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
            state_d    = SEND;
          end
        end
      end
      RX_ADDR: begin
        spi_addr_d = REG_BUSY;
        state_d    = RX_CAP;
      end
      RX_CAP: begin
        word_d[{byte_cnt_q[1:0], 3'b000} +: 8] = spi_rdata[7:0];
        if (byte_cnt_q == 3'd7) begin
          mem_wen_d   = 4'hF;
          mem_addr_d  = word_cnt_q[11:0];
          mem_wdata_d = {spi_rdata[7:0], word_q[23:0]};
          byte_cnt_d  = 3'd4;
          state_d     = MEM_WR;
        end else begin
          byte_cnt_d = byte_cnt_q + 3'd1;
          state_d    = SEND;
        end
      end
      MEM_WR: begin
        word_cnt_d = word_cnt_q + 13'd1;
        if (word_cnt_q == LAST_WORD) begin
          spi_wen_d   = 1'b1;
          spi_addr_d  = REG_CS;
          spi_wdata_d = 32'd1;
          state_d     = CS_HIGH;
        end else begin
          state_d = SEND;
        end
      end
      CS_HIGH: begin
        cpu_hold_d = 1'b0;
        done_d     = 1'b1;
        state_d    = DONE;
      end
      DONE: begin
        cpu_hold_d = 1'b0;
        done_d     = 1'b1;
      end
      default: state_d = IDLE_CS;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= IDLE_CS;
      byte_cnt_q <= 3'd0;
      poll_cnt_q <= 2'd0;
      word_cnt_q <= 13'd0;
      word_q     <= 32'd0;
      spi_wen    <= 1'b0;
      spi_addr   <= 32'd0;
      spi_wdata  <= 32'd0;
      mem_wen    <= 4'h0;
      mem_addr   <= 12'd0;
      mem_wdata  <= 32'd0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      word_cnt_q <= word_cnt_d;
      word_q     <= word_d;
      spi_wen    <= spi_wen_d;
      spi_addr   <= spi_addr_d;
      spi_wdata  <= spi_wdata_d;
      mem_wen    <= mem_wen_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      cpu_hold   <= cpu_hold_d;
      done       <= done_d;
    end
  end

endmodule
